bp_cfg_mmio_responder: RTL

BP_CFG_MMIO_RESPONDER -- requirements
Module: bp_cfg_mmio_responder

---
 rtl/bp_cfg_mmio_responder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/bp_cfg_mmio_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bp_cfg_mmio_responder                                         |
// | Purpose  : MMIO config responder for core control regs and CCE ucode.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module bp_cfg_mmio_responder #(
    parameter int cfg_core_width_p      = 8,
    parameter int cfg_addr_width_p      = 16,
    parameter int cfg_data_width_p      = 32,
    parameter int core_id_p             = 0,
    parameter int inst_width_p          = 48,
    parameter int inst_ram_addr_width_p = 8
) (
    input  logic                                                          clk_i,
    input  logic                                                          reset_n_i,
    input  logic                                                          mem_cmd_v_i,
    input  logic                                                          mem_cmd_wr_i,
    input  logic [cfg_core_width_p+cfg_addr_width_p+cfg_data_width_p-1:0] mem_cmd_data_i,
    output logic                                                          mem_cmd_yumi_o,
    output logic                                                          mem_resp_v_o,
    input  logic                                                          mem_resp_ready_i,
    output logic                                                          mem_resp_wr_o,
    output logic [cfg_data_width_p-1:0]                                   mem_resp_data_o,
    output logic                                                          reset_o,
    output logic                                                          freeze_o,
    output logic                                                          cce_mode_o,
    output logic                                                          icache_mode_o,
    output logic                                                          dcache_mode_o,
    output logic [2*cfg_data_width_p-1:0]                                 start_pc_o,
    output logic                                                          ucode_w_v_o,
    output logic [inst_ram_addr_width_p-1:0]                              ucode_addr_o,
    output logic [inst_width_p-1:0]                                       ucode_data_o
);

    localparam int CORE_W = cfg_core_width_p;
    localparam int ADDR_W = cfg_addr_width_p;
    localparam int DATA_W = cfg_data_width_p;
    localparam int INST_W = inst_width_p;
    localparam int IDX_W  = inst_ram_addr_width_p;
    localparam int HI_W   = inst_width_p - cfg_data_width_p;

    localparam logic [ADDR_W-1:0] ADDR_RESET  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_FREEZE = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_CCE    = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_ICACHE = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ADDR_DCACHE = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] ADDR_PC_LO  = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] ADDR_PC_HI  = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] UCODE_BASE  = ADDR_W'(32'h8000);
    localparam logic [CORE_W-1:0] CORE_ID     = CORE_W'(core_id_p);
    localparam logic [CORE_W-1:0] CORE_BCAST  = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                run_q;
    logic                cmd_accept;
    logic                resp_v;
    logic                cmd_wr_q;
    logic [CORE_W-1:0]   cmd_core_q;
    logic [ADDR_W-1:0]   cmd_addr_q;
    logic [DATA_W-1:0]   cmd_data_q;
    logic                resp_wr_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic                reset_q, freeze_q, cce_mode_q, icache_mode_q, dcache_mode_q;
    logic [DATA_W-1:0]   pc_lo_q, pc_hi_q;
    logic [DATA_W-1:0]   ucode_lo_q;
    logic                ucode_w_v_q;
    logic [IDX_W-1:0]    ucode_addr_q;
    logic [INST_W-1:0]   ucode_data_q;
    logic                for_me;
    logic                is_ucode;
    logic                decode_wr;
    logic [ADDR_W-1:0]   ucode_off;
    logic [IDX_W-1:0]    ucode_idx;
    logic [DATA_W-1:0]   rd_data;

    // Gates acceptance until one edge after reset release.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) run_q <= 1'b0;
        else            run_q <= 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cmd_accept = 1'b0;
        resp_v     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_accept = mem_cmd_v_i & run_q;
                if (cmd_accept) state_d = ST_DECODE;
            end
            ST_DECODE: state_d = ST_RESP;
            ST_RESP: begin
                resp_v = 1'b1;
                if (mem_resp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign for_me    = (cmd_core_q == CORE_ID) || (cmd_core_q == CORE_BCAST);
    assign is_ucode  = (cmd_addr_q >= UCODE_BASE);
    assign ucode_off = cmd_addr_q - UCODE_BASE;
    assign ucode_idx = IDX_W'(ucode_off >> 1);
    assign decode_wr = (state_q == ST_DECODE) && cmd_wr_q && for_me;

    always_comb begin
        rd_data = '0;
        if (for_me) begin
            if (is_ucode) begin
                rd_data = cmd_addr_q[0] ? DATA_W'(ucode_data_q[INST_W-1:DATA_W])
                                        : ucode_data_q[DATA_W-1:0];
            end else begin
                case (cmd_addr_q)
                    ADDR_RESET:  rd_data = DATA_W'(reset_q);
                    ADDR_FREEZE: rd_data = DATA_W'(freeze_q);
                    ADDR_CCE:    rd_data = DATA_W'(cce_mode_q);
                    ADDR_ICACHE: rd_data = DATA_W'(icache_mode_q);
                    ADDR_DCACHE: rd_data = DATA_W'(dcache_mode_q);
                    ADDR_PC_LO:  rd_data = pc_lo_q;
                    ADDR_PC_HI:  rd_data = pc_hi_q;
                    default:     rd_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_wr_q    <= 1'b0;
            cmd_core_q  <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            resp_wr_q   <= 1'b0;
            resp_data_q <= '0;
        end else begin
            if (cmd_accept) begin
                cmd_wr_q                               <= mem_cmd_wr_i;
                {cmd_core_q, cmd_addr_q, cmd_data_q}   <= mem_cmd_data_i;
            end
            // Response fields only change in DECODE, so they stay put through RESP.
            if (state_q == ST_DECODE) begin
                resp_wr_q   <= cmd_wr_q;
                resp_data_q <= cmd_wr_q ? '0 : rd_data;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            reset_q       <= 1'b1;
            freeze_q      <= 1'b1;
            cce_mode_q    <= 1'b0;
            icache_mode_q <= 1'b0;
            dcache_mode_q <= 1'b0;
            pc_lo_q       <= '0;
            pc_hi_q       <= '0;
        end else if (decode_wr && !is_ucode) begin
            case (cmd_addr_q)
                ADDR_RESET:  reset_q       <= cmd_data_q[0];
                ADDR_FREEZE: freeze_q      <= cmd_data_q[0];
                ADDR_CCE:    cce_mode_q    <= cmd_data_q[0];
                ADDR_ICACHE: icache_mode_q <= cmd_data_q[0];
                ADDR_DCACHE: dcache_mode_q <= cmd_data_q[0];
                ADDR_PC_LO:  pc_lo_q       <= cmd_data_q;
                ADDR_PC_HI:  pc_hi_q       <= cmd_data_q;
                default: ;
            endcase
        end
    end

    // High-word write commits with whatever low word is buffered, even if indices differ.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ucode_lo_q   <= '0;
            ucode_w_v_q  <= 1'b0;
            ucode_addr_q <= '0;
            ucode_data_q <= '0;
        end else begin
            ucode_w_v_q <= decode_wr && is_ucode && cmd_addr_q[0];
            if (decode_wr && is_ucode) begin
                if (cmd_addr_q[0]) begin
                    ucode_addr_q <= ucode_idx;
                    ucode_data_q <= {cmd_data_q[HI_W-1:0], ucode_lo_q};
                end else begin
                    ucode_lo_q <= cmd_data_q;
                end
            end
        end
    end

    assign mem_cmd_yumi_o  = cmd_accept;
    assign mem_resp_v_o    = resp_v;
    assign mem_resp_wr_o   = resp_wr_q;
    assign mem_resp_data_o = resp_data_q;
    assign reset_o         = reset_q;
    assign freeze_o        = freeze_q;
    assign cce_mode_o      = cce_mode_q;
    assign icache_mode_o   = icache_mode_q;
    assign dcache_mode_o   = dcache_mode_q;
    assign start_pc_o      = {pc_hi_q, pc_lo_q};
    assign ucode_w_v_o     = ucode_w_v_q;
    assign ucode_addr_o    = ucode_addr_q;
    assign ucode_data_o    = ucode_data_q;

endmodule
`default_nettype wire
